stopwatch_up: RTL and testbench
===============================

STOPWATCH_UP -- requirements
Module: stopwatch_up

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100_000_000, clk cycles per 1-s count tick.
REQ-002 SHALL have parameter SCAN_DIV, default 131_072, clk cycles per display-digit step.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port btn_start, input, 1, debounced one-cycle pulse.
REQ-006 SHALL have port btn_pause, input, 1, debounced one-cycle pulse.
REQ-007 SHALL have port btn_clear, input, 1, debounced one-cycle pulse.
REQ-008 SHALL have port ssd_out, output, 8, active-low segments {a,b,c,d,e,f,g,dp}; dp always 1.
REQ-009 SHALL have port ssd_ctrl, output, 4, active-low one-hot digit enable; bit 3 = minute tens.
REQ-010 SHALL have port led, output, 16, all ones when the stopwatch reaches full scale, else zero.

Function
REQ-011 SHALL hold four BCD digits, min_ten 0-5, min_one 0-9, sec_ten 0-5, sec_one 0-9, counting up from 00:00.
REQ-012 SHALL implement states IDLE, RUN, PAUSE, FULL.
REQ-013 IDLE: btn_start -> RUN; tick divider restarts at 0.
REQ-014 RUN: btn_pause -> PAUSE; btn_start ignored.
REQ-015 PAUSE: btn_start -> RUN; digits and divider value held.
REQ-016 Any state: btn_clear -> IDLE, digits 00:00, divider 0; clear wins over start/pause in the same cycle.
REQ-017 In RUN, divider counts 0..TICK_DIV-1; on the cycle it equals TICK_DIV-1 the digits increment by one second, with the cascade registered in that same cycle.
REQ-018 Carry rules: sec_one 9->0 carries to sec_ten; sec_ten 5->0 carries to min_one; min_one 9->0 carries to min_ten.
REQ-019 On the tick at 59:58 -> 59:59, SHALL enter FULL; FULL holds 59:59 with no wrap, led = 16'hFFFF, start/pause ignored.
REQ-020 Display scan counter SHALL cycle digits 3,2,1,0 every SCAN_DIV clk cycles in all states, independent of RUN.
REQ-021 Digit decode SHALL be standard 0-9 seven-segment; values 10-15 SHALL blank (all segments 1).

Reset
REQ-022 reset=0 at a clock edge SHALL force IDLE, digits 00:00, tick divider 0, scan index 3, led 0, ssd_ctrl 4'b0111, ssd_out = pattern for 0.
REQ-023 Reset mid-RUN SHALL discard any pending tick; a button pulse coincident with reset SHALL be ignored.

Configuration
REQ-024 With STOPWATCH_LAP_EN defined, btn_pause in RUN SHALL instead toggle lap-freeze: the display shows a snapshot of the digits while counting continues; a second btn_pause unfreezes; btn_clear also unfreezes; PAUSE is entered only from lap-free RUN via btn_start.
REQ-025 Without STOPWATCH_LAP_EN, no snapshot registers SHALL exist and REQ-014 applies unchanged.

Structure
REQ-026 Shared package stopwatch_pkg SHALL hold the state enum (IDLE/RUN/PAUSE/FULL), digit limit constants (9, 5), and the seven-segment decode table constants.
REQ-027 The digit scan/decode SHALL be one sub-module, ssd_scan (four BCD inputs -> ssd_out, ssd_ctrl); the state machine, divider, and BCD counters stay in the top.

Verification (TICK_DIV=4, SCAN_DIV=2)
REQ-028 reset low, then btn_start, run 40 clk -> display 00:10, state RUN, led 0.
REQ-029 at 00:03 in RUN, btn_pause, wait 20 clk, btn_start, 8 clk -> 00:05; no advance while paused.
REQ-030 preload path: run to 00:59 -> next tick 01:00; at 09:59 -> 10:00.
REQ-031 run to 59:59 -> FULL, led 16'hFFFF, further 100 clk and btn_start leave 59:59; btn_clear -> 00:00, led 0, IDLE.
REQ-032 btn_clear and btn_start in the same cycle in PAUSE -> IDLE, 00:00.
REQ-033 scan check: ssd_ctrl sequence 0111,1011,1101,1110 repeating every 2 clk; at 12:34, ssd_out matches digits 1,2,3,4 in order.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch_up slice: run-state encoding, BCD digit
// limits and the active-low seven-segment patterns {a,b,c,d,e,f,g,dp}.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        FULL  = 2'd3
    } state_e;

    localparam logic [3:0] ONES_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX = 4'd5;

    localparam logic [7:0] SEG_0     = 8'h03;
    localparam logic [7:0] SEG_1     = 8'h9F;
    localparam logic [7:0] SEG_2     = 8'h25;
    localparam logic [7:0] SEG_3     = 8'h0D;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h49;
    localparam logic [7:0] SEG_6     = 8'h41;
    localparam logic [7:0] SEG_7     = 8'h1F;
    localparam logic [7:0] SEG_8     = 8'h01;
    localparam logic [7:0] SEG_9     = 8'h09;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] segDecode(input logic [3:0] value);
        logic [7:0] seg;
        seg = SEG_BLANK;
        case (value)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/stopwatch_up_ssd_scan.sv
// Multiplexed four-digit display driver: steps the enabled digit 3,2,1,0 every
// SCAN_DIV clocks and decodes the selected BCD value to segments.
module ssd_scan
    import stopwatch_pkg::*;
#(
    parameter int SCAN_DIV = 131_072
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit3_i,
    input  logic [3:0] digit2_i,
    input  logic [3:0] digit1_i,
    input  logic [3:0] digit0_i,
    output logic [7:0] ssd_out,
    output logic [3:0] ssd_ctrl
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [SW-1:0] scanCnt_q, scanCnt_d;
    logic [1:0]    scanIdx_q, scanIdx_d;
    logic [3:0]    selDigit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            scanCnt_q <= '0;
            scanIdx_q <= 2'd3;
        end else begin
            scanCnt_q <= scanCnt_d;
            scanIdx_q <= scanIdx_d;
        end
    end

    // Index counts down and wraps 0 -> 3 through its own 2-bit overflow.
    always_comb begin
        scanCnt_d = scanCnt_q + SW'(1);
        scanIdx_d = scanIdx_q;
        if (scanCnt_q == SW'(SCAN_DIV - 1)) begin
            scanCnt_d = '0;
            scanIdx_d = scanIdx_q - 2'd1;
        end
    end

    always_comb begin
        ssd_ctrl = 4'b0111;
        selDigit = digit3_i;
        case (scanIdx_q)
            2'd3: begin ssd_ctrl = 4'b0111; selDigit = digit3_i; end
            2'd2: begin ssd_ctrl = 4'b1011; selDigit = digit2_i; end
            2'd1: begin ssd_ctrl = 4'b1101; selDigit = digit1_i; end
            2'd0: begin ssd_ctrl = 4'b1110; selDigit = digit0_i; end
            default: ;
        endcase
        ssd_out = segDecode(selDigit);
    end

endmodule

// File: rtl/stopwatch_up.sv
// MM:SS count-up stopwatch with start/pause/clear and a saturating 59:59 stop.
// Optional lap-freeze display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_up
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int SCAN_DIV = 131_072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_start,
    input  logic        btn_pause,
    input  logic        btn_clear,
    output logic [7:0]  ssd_out,
    output logic [3:0]  ssd_ctrl,
    output logic [15:0] led
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_e        state_q, state_d;
    logic [TW-1:0] tickCnt_q, tickCnt_d;
    logic [3:0]    secOne_q, secOne_d, secTen_q, secTen_d;
    logic [3:0]    minOne_q, minOne_d, minTen_q, minTen_d;
    logic [15:0]   shownDigits;
    logic          tickHit;
    logic          atLastStep;

`ifdef STOPWATCH_LAP_EN
    logic          lapFrozen_q, lapFrozen_d;
    logic [15:0]   lapSnap_q, lapSnap_d;
`endif

    assign tickHit    = (state_q == RUN) && (tickCnt_q == TW'(TICK_DIV - 1));
    assign atLastStep = (minTen_q == TENS_MAX) && (minOne_q == ONES_MAX) &&
                        (secTen_q == TENS_MAX) && (secOne_q == ONES_MAX - 4'd1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            tickCnt_q <= '0;
            secOne_q  <= '0;
            secTen_q  <= '0;
            minOne_q  <= '0;
            minTen_q  <= '0;
        end else begin
            state_q   <= state_d;
            tickCnt_q <= tickCnt_d;
            secOne_q  <= secOne_d;
            secTen_q  <= secTen_d;
            minOne_q  <= minOne_d;
            minTen_q  <= minTen_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            lapFrozen_q <= 1'b0;
            lapSnap_q   <= '0;
        end else begin
            lapFrozen_q <= lapFrozen_d;
            lapSnap_q   <= lapSnap_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        tickCnt_d = tickCnt_q;
        secOne_d  = secOne_q;
        secTen_d  = secTen_q;
        minOne_d  = minOne_q;
        minTen_d  = minTen_q;
`ifdef STOPWATCH_LAP_EN
        lapFrozen_d = lapFrozen_q;
        lapSnap_d   = lapSnap_q;
`endif
        case (state_q)
            IDLE: begin
                if (btn_start) begin
                    state_d   = RUN;
                    tickCnt_d = '0;
                end
            end
            RUN: begin
`ifdef STOPWATCH_LAP_EN
                if (btn_pause) begin
                    lapFrozen_d = !lapFrozen_q;
                    lapSnap_d   = {minTen_q, minOne_q, secTen_q, secOne_q};
                end else if (btn_start && !lapFrozen_q) begin
                    state_d = PAUSE;
                end
`else
                if (btn_pause) begin
                    state_d = PAUSE;
                end
`endif
                tickCnt_d = tickCnt_q + TW'(1);
                // One-second step with the full BCD carry chain resolved in this cycle.
                if (tickHit) begin
                    tickCnt_d = '0;
                    if (secOne_q == ONES_MAX) begin
                        secOne_d = '0;
                        if (secTen_q == TENS_MAX) begin
                            secTen_d = '0;
                            if (minOne_q == ONES_MAX) begin
                                minOne_d = '0;
                                minTen_d = minTen_q + 4'd1;
                            end else begin
                                minOne_d = minOne_q + 4'd1;
                            end
                        end else begin
                            secTen_d = secTen_q + 4'd1;
                        end
                    end else begin
                        secOne_d = secOne_q + 4'd1;
                    end
                    if (atLastStep) begin
                        state_d = FULL;
                    end
                end
            end
            PAUSE: begin
                if (btn_start) begin
                    state_d = RUN;
                end
            end
            FULL: ;
            default: state_d = IDLE;
        endcase
        if (btn_clear) begin
            state_d   = IDLE;
            tickCnt_d = '0;
            secOne_d  = '0;
            secTen_d  = '0;
            minOne_d  = '0;
            minTen_d  = '0;
`ifdef STOPWATCH_LAP_EN
            lapFrozen_d = 1'b0;
`endif
        end
    end

`ifdef STOPWATCH_LAP_EN
    assign shownDigits = lapFrozen_q ? lapSnap_q : {minTen_q, minOne_q, secTen_q, secOne_q};
`else
    assign shownDigits = {minTen_q, minOne_q, secTen_q, secOne_q};
`endif

    assign led = (state_q == FULL) ? 16'hFFFF : 16'h0000;

    ssd_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_ssd_scan (
        .clk      (clk),
        .reset    (reset),
        .digit3_i (shownDigits[15:12]),
        .digit2_i (shownDigits[11:8]),
        .digit1_i (shownDigits[7:4]),
        .digit0_i (shownDigits[3:0]),
        .ssd_out  (ssd_out),
        .ssd_ctrl (ssd_ctrl)
    );

endmodule

// File: tb/tb_stopwatch_up.sv
// Directed bench for stopwatch_up with TICK_DIV=4 and SCAN_DIV=2 (default build,
// STOPWATCH_LAP_EN undefined).
module tb_stopwatch_up;
    import stopwatch_pkg::*;

    logic        clk;
    logic        reset;
    logic        btn_start;
    logic        btn_pause;
    logic        btn_clear;
    logic [7:0]  ssd_out;
    logic [3:0]  ssd_ctrl;
    logic [15:0] led;

    int compareCount;
    int failCount;

    logic [15:0] timeNow;

    stopwatch_up #(
        .TICK_DIV (4),
        .SCAN_DIV (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_pause (btn_pause),
        .btn_clear (btn_clear),
        .ssd_out   (ssd_out),
        .ssd_ctrl  (ssd_ctrl),
        .led       (led)
    );

    assign timeNow = {dut.minTen_q, dut.minOne_q, dut.secTen_q, dut.secOne_q};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic runCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle button pulse spanning exactly one rising edge.
    task automatic applyStimulus(input logic s, input logic p, input logic c);
        btn_start = s;
        btn_pause = p;
        btn_clear = c;
        runCycles(1);
        btn_start = 1'b0;
        btn_pause = 1'b0;
        btn_clear = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkStatus(input string tag, input logic [15:0] expTime,
                               input state_e expState, input logic [15:0] expLed);
        checkOutput({tag, "_time"}, 32'(timeNow), 32'(expTime));
        checkOutput({tag, "_state"}, 32'(dut.state_q), 32'(expState));
        checkOutput({tag, "_led"}, 32'(led), 32'(expLed));
    endtask

    initial begin
        logic [3:0] ctrlSeq [4];
        logic [7:0] segSeq  [4];
        logic [3:0] prevCtrl;
        logic       found;

        compareCount = 0;
        failCount    = 0;
        reset        = 1'b0;
        btn_start    = 1'b0;
        btn_pause    = 1'b0;
        btn_clear    = 1'b0;
        ctrlSeq[0] = 4'b0111; ctrlSeq[1] = 4'b1011; ctrlSeq[2] = 4'b1101; ctrlSeq[3] = 4'b1110;
        segSeq[0]  = 8'h9F;   segSeq[1]  = 8'h25;   segSeq[2]  = 8'h0D;   segSeq[3]  = 8'h99;

        // Reset state, with a start pulse coincident with reset that must be ignored.
        runCycles(2);
        btn_start = 1'b1;
        runCycles(1);
        btn_start = 1'b0;
        checkStatus("reset", 16'h0000, IDLE, 16'h0000);
        checkOutput("reset_ctrl", 32'(ssd_ctrl), 32'(4'b0111));
        checkOutput("reset_seg", 32'(ssd_out), 32'(8'h03));

        reset = 1'b1;
        runCycles(2);
        checkOutput("scan_first_step", 32'(ssd_ctrl), 32'(4'b1011));
        checkOutput("scan_first_seg", 32'(ssd_out), 32'(8'h03));
        checkStatus("idle_hold", 16'h0000, IDLE, 16'h0000);

        applyStimulus(1'b1, 1'b0, 1'b0);
        runCycles(40);
        checkStatus("run40", 16'h0010, RUN, 16'h0000);

        applyStimulus(1'b0, 1'b0, 1'b1);
        checkStatus("clear_run", 16'h0000, IDLE, 16'h0000);

        applyStimulus(1'b1, 1'b0, 1'b0);
        runCycles(12);
        checkStatus("at0003", 16'h0003, RUN, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0);
        runCycles(20);
        checkStatus("paused", 16'h0003, PAUSE, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0);
        runCycles(8);
        checkStatus("resume", 16'h0005, RUN, 16'h0000);

        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkStatus("clear_wins", 16'h0000, IDLE, 16'h0000);

        applyStimulus(1'b1, 1'b0, 1'b0);
        runCycles(236);
        checkStatus("at0059", 16'h0059, RUN, 16'h0000);
        runCycles(4);
        checkStatus("at0100", 16'h0100, RUN, 16'h0000);
        runCycles(2156);
        checkStatus("at0959", 16'h0959, RUN, 16'h0000);
        runCycles(4);
        checkStatus("at1000", 16'h1000, RUN, 16'h0000);
        runCycles(616);
        checkStatus("at1234", 16'h1234, RUN, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkStatus("pause1234", 16'h1234, PAUSE, 16'h0000);

        // Align to the first cycle of the minute-tens digit, then walk two full scan passes.
        found    = 1'b0;
        prevCtrl = ssd_ctrl;
        for (int i = 0; i < 10 && !found; i++) begin
            runCycles(1);
            if (ssd_ctrl == 4'b0111 && prevCtrl != 4'b0111) found = 1'b1;
            prevCtrl = ssd_ctrl;
        end
        checkOutput("scan_sync", 32'(found), 32'(1'b1));
        if (found) begin
            for (int k = 0; k < 16; k++) begin
                checkOutput($sformatf("scan_ctrl_%0d", k), 32'(ssd_ctrl), 32'(ctrlSeq[(k / 2) % 4]));
                checkOutput($sformatf("scan_seg_%0d", k), 32'(ssd_out), 32'(segSeq[(k / 2) % 4]));
                runCycles(1);
            end
        end

        applyStimulus(1'b1, 1'b0, 1'b0);
        runCycles(11375);
        checkStatus("at5958", 16'h5958, RUN, 16'h0000);
        runCycles(3);
        checkStatus("at5958_late", 16'h5958, RUN, 16'h0000);
        runCycles(1);
        checkStatus("full", 16'h5959, FULL, 16'hFFFF);
        runCycles(100);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkStatus("full_hold", 16'h5959, FULL, 16'hFFFF);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkStatus("full_clear", 16'h0000, IDLE, 16'h0000);

        applyStimulus(1'b1, 1'b0, 1'b0);
        runCycles(3);
        reset = 1'b0;
        runCycles(1);
        reset = 1'b1;
        checkStatus("midrun_reset", 16'h0000, IDLE, 16'h0000);
        runCycles(4);
        checkStatus("after_reset", 16'h0000, IDLE, 16'h0000);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
